dest_pop_arbiter: RTL

- Schedules reads from the two source FIFOs (FWFT, first-word-fall-through) that feed the 2:1 destination-routing mux.
- Generates pop0/pop1 with weighted round-robin: each source gets up to BURST_LEN consecutive pops before yielding.
- Gates each pop on the almost_full of the destination FIFO selected by the head word.
- Registers the selected word and steers it to one of two destination FIFO push strobes.

---
 rtl/dest_pop_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dest_pop_arbiter.sv
// Weighted round-robin pop scheduler for two FWFT source FIFOs feeding a 2:1 destination mux.
// Pops are gated by the almost_full of the destination named in each head word; the popped word is registered.
module dest_pop_arbiter #(
    parameter int DATA_W    = 10,
    parameter int DEST_BIT  = 9,
    parameter int BURST_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty0,
    input  logic              fifo_empty1,
    input  logic [DATA_W-1:0] datain_dest0,
    input  logic [DATA_W-1:0] datain_dest1,
    input  logic              almost_full_d0,
    input  logic              almost_full_d1,
    output logic              pop0,
    output logic              pop1,
    output logic [DATA_W-1:0] dataout_dest,
    output logic              push_d0,
    output logic              push_d1,
    output logic              validoutdest
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [2:0] BURST = 3'(BURST_LEN);

    state_t            state;
    logic [2:0]        cnt;
    logic              last;

    logic              elig0;
    logic              elig1;
    logic              cur_src;
    logic              elig_cur;
    logic              elig_oth;
    logic              gnt_valid;
    logic              gnt_src;
    logic [2:0]        cnt_next;
    logic [DATA_W-1:0] sel_word;

    // A head is eligible only if the destination it targets can take one more word.
    assign elig0 = !fifo_empty0 &&
                   !(datain_dest0[DEST_BIT] ? almost_full_d1 : almost_full_d0);
    assign elig1 = !fifo_empty1 &&
                   !(datain_dest1[DEST_BIT] ? almost_full_d1 : almost_full_d0);

    assign cur_src  = (state == GRANT1);
    assign elig_cur = cur_src ? elig1 : elig0;
    assign elig_oth = cur_src ? elig0 : elig1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        gnt_valid = 1'b0;
        gnt_src   = 1'b0;
        cnt_next  = 3'd0;
        case (state)
            GRANT0, GRANT1: begin
                if (cnt < BURST && elig_cur) begin
                    gnt_valid = 1'b1;
                    gnt_src   = cur_src;
                    cnt_next  = cnt + 3'd1;
                end else if (elig_oth) begin
                    gnt_valid = 1'b1;
                    gnt_src   = ~cur_src;
                    cnt_next  = 3'd1;
                end else if (elig_cur) begin
                    // Other side idle: the same source keeps going on a fresh burst.
                    gnt_valid = 1'b1;
                    gnt_src   = cur_src;
                    cnt_next  = 3'd1;
                end
            end
            default: begin
                if (last ? elig0 : elig1) begin
                    gnt_valid = 1'b1;
                    gnt_src   = ~last;
                    cnt_next  = 3'd1;
                end else if (last ? elig1 : elig0) begin
                    gnt_valid = 1'b1;
                    gnt_src   = last;
                    cnt_next  = 3'd1;
                end
            end
        endcase
    end

    assign pop0     = !reset && gnt_valid && !gnt_src;
    assign pop1     = !reset && gnt_valid &&  gnt_src;
    assign sel_word = gnt_src ? datain_dest1 : datain_dest0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            last         <= 1'b1;
            dataout_dest <= '0;
            push_d0      <= 1'b0;
            push_d1      <= 1'b0;
            validoutdest <= 1'b0;
        end else if (gnt_valid) begin
            state        <= gnt_src ? GRANT1 : GRANT0;
            cnt          <= cnt_next;
            dataout_dest <= sel_word;
            push_d0      <= !sel_word[DEST_BIT];
            push_d1      <=  sel_word[DEST_BIT];
            validoutdest <= 1'b1;
        end else begin
            state        <= IDLE;
            cnt          <= 3'd0;
            if (state != IDLE) begin
                last <= cur_src;
            end
            push_d0      <= 1'b0;
            push_d1      <= 1'b0;
            validoutdest <= 1'b0;
        end
    end

endmodule
